gcd_controller: RTL and testbench
=================================

# gcd_controller

Control FSM for the 16-bit subtractive GCD datapath. It loads two operands from the shared `data_in` bus into the A and B registers through a valid/ready handshake. It then issues subtract-and-load steps driven by the datapath's `gt`/`lt`/`eq` flags until the registers are equal, and flags completion with a one-cycle `done`. The result is read from the datapath's A register.

## Interface
- `MAX_ITER`, default 65535: subtract-step limit before abort (used only with `GCD_TIMEOUT_EN`).
- `CNT_W`, default 17: iteration counter width; must satisfy 2^CNT_W > `MAX_ITER`.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: request a new GCD; sampled only in IDLE.
- `op_valid` in 1: operand present on the datapath `data_in`.
- `op_ready` out 1: controller accepts an operand this cycle.
- `gt`, `lt`, `eq` in 1 each: datapath compare flags for A>B, A<B and A==B.
- `LdA`, `LdB` out 1 each: register load enables.
- `sel1` out 1: subtractor X mux; 0 selects A, 1 selects B.
- `sel2` out 1: subtractor Y mux; 0 selects A, 1 selects B.
- `sel_in` out 1: load bus mux; 1 selects `data_in`, 0 selects the subtractor output.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: iteration limit hit; forced to 0 without `GCD_TIMEOUT_EN`.

## Operation
- States: IDLE, LOAD_A, LOAD_B, CALC, DONE.
- IDLE:
  - All outputs 0.
  - `start`=1 moves to LOAD_A, clears `err` and clears the iteration counter.
- LOAD_A:
  - `op_ready`=1, `sel_in`=1, `LdA`=`op_valid`.
  - Advances to LOAD_B only when `op_valid`=1; otherwise holds.
- LOAD_B:
  - Same as LOAD_A with `LdB`.
  - Advances to CALC when `op_valid`=1.
  - Flags are ignored in this state because B is stale.
- CALC (`sel_in`=0):
  - `eq`=1: no load; go to DONE.
  - `gt`=1: `sel1`=0, `sel2`=1, `LdA`=1, so A <= A−B. Counter increments.
  - `lt`=1: `sel1`=1, `sel2`=0, `LdB`=1, so B <= B−A. Counter increments.
  - Flag priority is `eq` > `gt` > `lt`. The datapath guarantees the three flags are mutually exclusive.
- DONE: `done`=1 for exactly one cycle, then unconditionally to IDLE. `start` is ignored in DONE.
- `LdA`, `LdB`, `sel1`, `sel2` and `op_ready` are combinational (Mealy) from state, `op_valid` and flags. `busy` and `done` are decoded from state only.
- Operands are unsigned 16-bit. Operand 0 gives an infinite loop, since the flag stays `lt` or `gt` with no change. Callers must not issue 0 unless `GCD_TIMEOUT_EN` is set.
- The result is valid in the A register from the `done` cycle until the next LOAD_A load.

## Timing
- Reset (asynchronous assert):
  - State goes to IDLE; counter goes to 0.
  - All outputs become 0 immediately.
  - Reset release is synchronous to `clk`.
- Reset mid-operation abandons the computation. A/B contents are undefined for the caller, and no `done` is produced.
- With `start` at cycle 0 and `op_valid` held high:
  - LOAD_A at cycle 1, LOAD_B at cycle 2, CALC from cycle 3.
  - `done` at cycle 4+N, where N is the number of subtract steps.
- Each stall cycle (`op_valid` low in LOAD_A or LOAD_B) adds one cycle.
- `start` held high through DONE does not retrigger until IDLE is re-entered, one cycle after DONE.

## Configuration
- `GCD_TIMEOUT_EN` defined:
  - A `CNT_W`-bit counter counts CALC subtract steps.
  - In CALC with `eq`=0 and counter == `MAX_ITER`: no load, `err` <= 1, go to DONE.
  - `err` holds until the next accepted `start`.
- Not defined:
  - No counter logic.
  - `err` is tied to 0.
  - CALC loops until `eq`.

## Structure
- Package `gcd_pkg`:
  - State enum `gcd_state_t` (IDLE, LOAD_A, LOAD_B, CALC, DONE).
  - `GCD_DW`=16.
  - Mux select constants `SEL_A`=0, `SEL_B`=1, `SEL_BUS`=1, `SEL_SUB`=0.
- One sub-module, `gcd_iter_counter`: clear, increment, and limit-compare. It is instantiated only under `GCD_TIMEOUT_EN`.

## Test plan
- GCD(12,8), `op_valid` held high, `start` at cycle 0:
  - Load sequence A=4, then B=4, then `eq`.
  - `done` at cycle 6; A=4.
- GCD(65535,1): 65534 steps, `done` at cycle 65538, A=1, `err`=0 (with the macro).
- `op_valid` low for 3 cycles in LOAD_A and 2 cycles in LOAD_B on GCD(9,6):
  - `op_ready` stays high; no loads occur while `op_valid` is low.
  - `done` arrives 5 cycles later than the unstalled run; A=3.
- GCD(0,7) with `GCD_TIMEOUT_EN`, `MAX_ITER`=10: after 10 `LdB` pulses, `done`=1 and `err`=1; `err` clears on the next accepted `start`.
- `rst_n` asserted low during CALC of GCD(100,75): outputs go to 0 asynchronously and the FSM returns to IDLE. A following GCD(21,14) yields A=7.
- `start` held high continuously over GCD(5,5): `done` at cycle 4, IDLE at cycle 5, new LOAD_A at cycle 6.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and constants for the subtractive GCD controller.
// Mux select encodings match the datapath's sel1/sel2/sel_in wiring.
package gcd_pkg;

    localparam int GCD_DW = 16;

    localparam logic SEL_A   = 1'b0;
    localparam logic SEL_B   = 1'b1;
    localparam logic SEL_BUS = 1'b1;
    localparam logic SEL_SUB = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        CALC,
        DONE
    } gcd_state_t;

endpackage

// File: rtl/gcd_iter_counter.sv
// Subtract-step counter: clear, increment, and compare against MAX_ITER.
// Latency: at_limit_o is a combinational compare of the registered count; no backpressure.
module gcd_iter_counter #(
    parameter int MAX_ITER = 65535,
    parameter int CNT_W    = 17
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic at_limit_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign at_limit_o = (cnt_q == CNT_W'(MAX_ITER));

endmodule

// File: rtl/gcd_controller.sv
// Control FSM for the 16-bit subtractive GCD datapath; optional step-limit abort under GCD_TIMEOUT_EN.
// Latency: done at 4+N cycles after start (N subtract steps) plus one per operand stall; op_ready held while op_valid is low.
module gcd_controller
    import gcd_pkg::*;
#(
    parameter int MAX_ITER = 65535,
    parameter int CNT_W    = 17
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic op_valid,
    output logic op_ready,
    input  logic gt,
    input  logic lt,
    input  logic eq,
    output logic LdA,
    output logic LdB,
    output logic sel1,
    output logic sel2,
    output logic sel_in,
    output logic busy,
    output logic done,
    output logic err
);

    if ((64'd1 << CNT_W) <= 64'(MAX_ITER)) begin : g_cfg_check
        $error("CNT_W too narrow to hold MAX_ITER");
    end

    gcd_state_t state_q;
    logic       at_limit;
    logic       sub_a;
    logic       sub_b;

    // eq wins over gt, gt over lt; a step at the limit is suppressed in favour of the abort
    assign sub_a = (state_q == CALC) && !eq && !at_limit && gt;
    assign sub_b = (state_q == CALC) && !eq && !at_limit && !gt && lt;

`ifdef GCD_TIMEOUT_EN
    logic err_q;

    gcd_iter_counter #(
        .MAX_ITER (MAX_ITER),
        .CNT_W    (CNT_W)
    ) u_iter_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      ((state_q == IDLE) && start),
        .inc_i      (sub_a || sub_b),
        .at_limit_o (at_limit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if ((state_q == IDLE) && start) begin
            err_q <= 1'b0;
        end else if ((state_q == CALC) && !eq && at_limit) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign at_limit = 1'b0;
    assign err      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start)    state_q <= LOAD_A;
                LOAD_A:  if (op_valid) state_q <= LOAD_B;
                LOAD_B:  if (op_valid) state_q <= CALC;
                CALC:    if (eq || at_limit) state_q <= DONE;
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        op_ready = 1'b0;
        sel_in   = SEL_SUB;
        LdA      = 1'b0;
        LdB      = 1'b0;
        sel1     = SEL_A;
        sel2     = SEL_A;
        case (state_q)
            LOAD_A: begin
                op_ready = 1'b1;
                sel_in   = SEL_BUS;
                LdA      = op_valid;
            end
            LOAD_B: begin
                op_ready = 1'b1;
                sel_in   = SEL_BUS;
                LdB      = op_valid;
            end
            CALC: begin
                if (sub_a) begin
                    LdA  = 1'b1;
                    sel1 = SEL_A;
                    sel2 = SEL_B;
                end else if (sub_b) begin
                    LdB  = 1'b1;
                    sel1 = SEL_B;
                    sel2 = SEL_A;
                end
            end
            default: ;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_gcd_controller.sv
// Randomised scoreboard bench for gcd_controller with a behavioural datapath and Euclid-based reference.
// Set GCD_TIMEOUT_EN to also exercise the step-limit abort (MAX_ITER=10).
module tb_gcd_controller;

`ifdef GCD_TIMEOUT_EN
    localparam int MAXI = 10;
`else
    localparam int MAXI = 65535;
`endif

    logic clk = 1'b0;
    logic rst_n, start, op_valid, op_ready, gt, lt, eq;
    logic LdA, LdB, sel1, sel2, sel_in, busy, done, err;
    logic [15:0] data_in = '0;
    logic [15:0] a_q = '0;
    logic [15:0] b_q = '0;
    logic [15:0] sub_res;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int step_cnt = 0;
    bit chk_idle = 0;

    typedef struct {
        int res;
        int steps;
        int cyc;
        bit err;
    } exp_t;
    exp_t exp_q[$];

    gcd_controller #(.MAX_ITER(MAXI), .CNT_W(17)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_valid(op_valid), .op_ready(op_ready),
        .gt(gt), .lt(lt), .eq(eq), .LdA(LdA), .LdB(LdB), .sel1(sel1), .sel2(sel2),
        .sel_in(sel_in), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Datapath model: A/B registers, subtractor with operand muxes, compare flags
    assign gt = (a_q > b_q);
    assign lt = (a_q < b_q);
    assign eq = (a_q == b_q);
    assign sub_res = (sel1 ? b_q : a_q) - (sel2 ? b_q : a_q);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (LdA) a_q <= sel_in ? data_in : sub_res;
        if (LdB) b_q <= sel_in ? data_in : sub_res;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    // Euclid: subtract steps = sum of quotients - 1; a zero operand never converges
    task automatic ref_model(input int a, input int b, output int g, output int steps, output bit inf);
        int x, y, t, sum;
        inf = 0;
        if (a == b) begin
            g = a; steps = 0;
        end else if (a == 0 || b == 0) begin
            g = 0; steps = 0; inf = 1;
        end else begin
            x = a; y = b; sum = 0;
            while (y != 0) begin
                sum += x / y;
                t = x % y; x = y; y = t;
            end
            g = x; steps = sum - 1;
        end
    endtask

    task automatic push_exp(input int a, input int b, input int s, input int stalls);
        exp_t e;
        int g, n;
        bit inf;
        ref_model(a, b, g, n, inf);
        e.err   = inf || (n > MAXI);
        e.res   = g;
        e.steps = e.err ? MAXI : n;
        e.cyc   = s + 4 + e.steps + stalls;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 70000; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        errors++;
        $display("FAIL idle_timeout: busy still %0d expected 0", busy);
        finish_sim();
    endtask

    task automatic issue(input int a, input int b, input int sa, input int sb);
        int s;
        wait_idle();
        start = 1; op_valid = 0; data_in = 16'(a);
        s = cyc;
        push_exp(a, b, s, sa + sb);
        @(negedge clk);
        start = 0;
        for (int i = 0; i < sa; i++) begin
            op_valid = 0; #1;
            check("stallA_ready", op_ready, 1);
            check("stallA_noload", LdA, 0);
            @(negedge clk);
        end
        op_valid = 1; data_in = 16'(a);
        @(negedge clk);
        for (int i = 0; i < sb; i++) begin
            op_valid = 0; #1;
            check("stallB_ready", op_ready, 1);
            check("stallB_noload", LdB, 0);
            @(negedge clk);
        end
        op_valid = 1; data_in = 16'(b);
        @(negedge clk);
        op_valid = 0;
    endtask

    // Monitor: counts subtract steps and scores each done pulse against the queue head
    always @(negedge clk) begin
        if (rst_n) begin
            if (chk_idle) begin
                check("done_one_cycle", done, 0);
                check("idle_after_done", busy, 0);
                chk_idle = 0;
            end
            if (busy && !sel_in && (LdA || LdB)) step_cnt++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL unexpected_done: got done=1 expected no pending job");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("done_cycle", cyc, e.cyc);
                    check("err_flag", err, e.err);
                    check("step_count", step_cnt, e.steps);
                    if (!e.err) check("result_A", a_q, e.res);
                end
                step_cnt = 0;
                chk_idle = 1;
            end
        end
    end

    initial begin
        int s;
        rst_n = 0; start = 0; op_valid = 0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_outs", {op_ready, LdA, LdB, sel1, sel2, sel_in, done, err}, 0);
        @(negedge clk); rst_n = 1;

        issue(12, 8, 0, 0);
        issue(9, 6, 0, 0);
        issue(9, 6, 3, 2);
        issue(65535, 1, 0, 0);

`ifdef GCD_TIMEOUT_EN
        issue(0, 7, 0, 0);
        wait_idle();
        check("err_holds", err, 1);
        issue(6, 4, 0, 0);
        check("err_cleared", err, 0);
`endif

        // Asynchronous reset in the middle of CALC abandons the job
        issue(100, 75, 0, 0);
        @(negedge clk);
        #1 rst_n = 0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_outs", {op_ready, LdA, LdB, sel1, sel2, sel_in, done, err}, 0);
        exp_q.delete();
        step_cnt = 0; chk_idle = 0;
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        issue(21, 14, 0, 0);

        // start held high across a whole job retriggers only once IDLE is re-entered
        wait_idle();
        start = 1; op_valid = 1; data_in = 16'd5;
        s = cyc;
        push_exp(5, 5, s, 0);
        push_exp(5, 5, s + 5, 0);
        while (cyc < s + 6) @(negedge clk);
        check("retrigger_busy", busy, 1);
        check("retrigger_ready", op_ready, 1);
        start = 0;

        for (int i = 0; i < 12; i++) begin
            issue($urandom_range(255, 1), $urandom_range(255, 1),
                  $urandom_range(3, 0), $urandom_range(3, 0));
        end

        wait_idle();
        @(negedge clk); @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        finish_sim();
    end

endmodule
